// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MIPS-32 write-back stage, 32x32 register file and jump redirect register
module wb_regfile #(
  parameter int LINK_REG = 31
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        RegWrite_WB,
  input  logic        MemtoReg_WB,
  input  logic [31:0] ReadData_WB,
  input  logic [31:0] ALUResult_WB,
  input  logic [4:0]  WriteReg_WB,
  input  logic        IsJal_WB,
  input  logic [1:0]  Jump_WB,
  input  logic [31:0] PC_WB,
  input  logic [27:0] out1_WB,
  input  logic [31:0] ReadData1_WB,
  input  logic [4:0]  ReadReg1_ID,
  input  logic [4:0]  ReadReg2_ID,
  output logic [31:0] ReadData1_ID,
  output logic [31:0] ReadData2_ID,
  output logic [31:0] WriteData_WB,
  output logic        Redirect,
  output logic [31:0] Target
);

  localparam logic [4:0] LINK_IDX = 5'(LINK_REG);

  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_ABS  = 2'b01;
  localparam logic [1:0] JUMP_REG  = 2'b10;

  logic [31:0] regs [0:31];
  logic [4:0]  write_idx;
  logic        commit;

  // Select the write-back value and destination; JAL overrides both
  always_comb begin
    WriteData_WB = ALUResult_WB;
    write_idx    = WriteReg_WB;
    if (IsJal_WB) begin
      WriteData_WB = PC_WB;
      write_idx    = LINK_IDX;
    end else if (MemtoReg_WB) begin
      WriteData_WB = ReadData_WB;
    end
    commit = (RegWrite_WB || IsJal_WB) && (write_idx != 5'd0);
  end

  // Read ports: $0 is hard zero, otherwise bypass the committing value over the stored one
  always_comb begin
    ReadData1_ID = regs[ReadReg1_ID];
    ReadData2_ID = regs[ReadReg2_ID];
    if (commit && (ReadReg1_ID == write_idx)) ReadData1_ID = WriteData_WB;
    if (commit && (ReadReg2_ID == write_idx)) ReadData2_ID = WriteData_WB;
    if (ReadReg1_ID == 5'd0) ReadData1_ID = 32'd0;
    if (ReadReg2_ID == 5'd0) ReadData2_ID = 32'd0;
  end

  // Register file commit; reset clears every entry and drops this cycle's write
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (commit) begin
      regs[write_idx] <= WriteData_WB;
    end
  end

  // Redirect pulse and held target, one cycle after the jump is seen in WB
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      Redirect <= 1'b0;
      Target   <= 32'd0;
    end else begin
      case (Jump_WB)
        JUMP_ABS: begin
          Redirect <= 1'b1;
          Target   <= {PC_WB[31:28], out1_WB};
        end
        JUMP_REG: begin
          Redirect <= 1'b1;
          Target   <= ReadData1_WB;
        end
        default: Redirect <= 1'b0;
      endcase
    end
  end

  wire unused_none = (JUMP_NONE == 2'b00);

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - table-driven self-checking bench for wb_regfile
module tb_wb_regfile;

  logic        Clk;
  logic        Reset;
  logic        RegWrite_WB;
  logic        MemtoReg_WB;
  logic [31:0] ReadData_WB;
  logic [31:0] ALUResult_WB;
  logic [4:0]  WriteReg_WB;
  logic        IsJal_WB;
  logic [1:0]  Jump_WB;
  logic [31:0] PC_WB;
  logic [27:0] out1_WB;
  logic [31:0] ReadData1_WB;
  logic [4:0]  ReadReg1_ID;
  logic [4:0]  ReadReg2_ID;
  logic [31:0] ReadData1_ID;
  logic [31:0] ReadData2_ID;
  logic [31:0] WriteData_WB;
  logic        Redirect;
  logic [31:0] Target;

  wb_regfile #(.LINK_REG(31)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .RegWrite_WB  (RegWrite_WB),
    .MemtoReg_WB  (MemtoReg_WB),
    .ReadData_WB  (ReadData_WB),
    .ALUResult_WB (ALUResult_WB),
    .WriteReg_WB  (WriteReg_WB),
    .IsJal_WB     (IsJal_WB),
    .Jump_WB      (Jump_WB),
    .PC_WB        (PC_WB),
    .out1_WB      (out1_WB),
    .ReadData1_WB (ReadData1_WB),
    .ReadReg1_ID  (ReadReg1_ID),
    .ReadReg2_ID  (ReadReg2_ID),
    .ReadData1_ID (ReadData1_ID),
    .ReadData2_ID (ReadData2_ID),
    .WriteData_WB (WriteData_WB),
    .Redirect     (Redirect),
    .Target       (Target)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic        rst_n;
    logic        rw;
    logic        m2r;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic        jal;
    logic [1:0]  jump;
    logic [31:0] pc;
    logic [27:0] o1;
    logic [31:0] rd1wb;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic [31:0] e_wd;
    logic        e_redir;
    logic [31:0] e_tgt;
  } vec_t;

  int tests = 0;
  int fails = 0;

  function automatic vec_t mk(
    input logic rst_n, input logic rw, input logic m2r,
    input logic [31:0] rdata, input logic [31:0] alu, input logic [4:0] wr,
    input logic jal, input logic [1:0] jump, input logic [31:0] pc,
    input logic [27:0] o1, input logic [31:0] rd1wb,
    input logic [4:0] ra1, input logic [4:0] ra2,
    input logic [31:0] e_rd1, input logic [31:0] e_rd2, input logic [31:0] e_wd,
    input logic e_redir, input logic [31:0] e_tgt);
    vec_t v;
    v.rst_n = rst_n; v.rw = rw; v.m2r = m2r; v.rdata = rdata; v.alu = alu;
    v.wr = wr; v.jal = jal; v.jump = jump; v.pc = pc; v.o1 = o1; v.rd1wb = rd1wb;
    v.ra1 = ra1; v.ra2 = ra2; v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_wd = e_wd;
    v.e_redir = e_redir; v.e_tgt = e_tgt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one WB cycle, check combinational outputs mid-cycle and registered ones after the edge
  task automatic apply(input string tag, input vec_t v);
    @(negedge Clk);
    Reset        = v.rst_n;
    RegWrite_WB  = v.rw;
    MemtoReg_WB  = v.m2r;
    ReadData_WB  = v.rdata;
    ALUResult_WB = v.alu;
    WriteReg_WB  = v.wr;
    IsJal_WB     = v.jal;
    Jump_WB      = v.jump;
    PC_WB        = v.pc;
    out1_WB      = v.o1;
    ReadData1_WB = v.rd1wb;
    ReadReg1_ID  = v.ra1;
    ReadReg2_ID  = v.ra2;
    #2;
    chk({tag, " rd1"}, ReadData1_ID, v.e_rd1);
    chk({tag, " rd2"}, ReadData2_ID, v.e_rd2);
    chk({tag, " wdata"}, WriteData_WB, v.e_wd);
    @(posedge Clk);
    #1;
    chk({tag, " redirect"}, {31'd0, Redirect}, {31'd0, v.e_redir});
    chk({tag, " target"}, Target, v.e_tgt);
  endtask

  vec_t vecs [16];

  initial begin
    Reset = 1'b0; RegWrite_WB = 1'b0; MemtoReg_WB = 1'b0; ReadData_WB = '0;
    ALUResult_WB = '0; WriteReg_WB = '0; IsJal_WB = 1'b0; Jump_WB = 2'b00;
    PC_WB = '0; out1_WB = '0; ReadData1_WB = '0; ReadReg1_ID = '0; ReadReg2_ID = '0;

    //            rst rw m2r rdata         alu           wr  jal jump  pc            o1           rd1wb  ra1 ra2  e_rd1         e_rd2         e_wd          red e_tgt
    vecs[0]  = mk(0, 0, 0, 32'h0,        32'h0,        0,  0, 2'b00, 32'h0,        28'h0,       32'h0, 5,  6,  32'h0,        32'h0,        32'h0,        0, 32'h0);
    vecs[1]  = mk(1, 1, 0, 32'h0,        32'h1234,     5,  0, 2'b00, 32'h0,        28'h0,       32'h0, 5,  0,  32'h1234,     32'h0,        32'h1234,     0, 32'h0);
    vecs[2]  = mk(1, 0, 0, 32'h0,        32'h0,        0,  0, 2'b00, 32'h0,        28'h0,       32'h0, 5,  6,  32'h1234,     32'h0,        32'h0,        0, 32'h0);
    vecs[3]  = mk(0, 0, 0, 32'h0,        32'h0,        0,  0, 2'b00, 32'h0,        28'h0,       32'h0, 5,  6,  32'h1234,     32'h0,        32'h0,        0, 32'h0);
    vecs[4]  = mk(0, 0, 0, 32'h0,        32'h0,        0,  0, 2'b00, 32'h0,        28'h0,       32'h0, 5,  6,  32'h0,        32'h0,        32'h0,        0, 32'h0);
    vecs[5]  = mk(1, 0, 0, 32'h0,        32'h0,        0,  0, 2'b00, 32'h0,        28'h0,       32'h0, 5,  5,  32'h0,        32'h0,        32'h0,        0, 32'h0);
    vecs[6]  = mk(1, 1, 0, 32'h11111111, 32'hA5A5A5A5, 8,  0, 2'b00, 32'h0,        28'h0,       32'h0, 8,  9,  32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 0, 32'h0);
    vecs[7]  = mk(1, 1, 1, 32'hDEADBEEF, 32'h22222222, 9,  0, 2'b00, 32'h0,        28'h0,       32'h0, 8,  9,  32'hA5A5A5A5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 32'h0);
    vecs[8]  = mk(1, 0, 0, 32'h0,        32'h0,        0,  0, 2'b00, 32'h0,        28'h0,       32'h0, 9,  8,  32'hDEADBEEF, 32'hA5A5A5A5, 32'h0,        0, 32'h0);
    vecs[9]  = mk(1, 1, 0, 32'h0,        32'hFFFFFFFF, 0,  0, 2'b00, 32'h0,        28'h0,       32'h0, 0,  0,  32'h0,        32'h0,        32'hFFFFFFFF, 0, 32'h0);
    vecs[10] = mk(1, 0, 0, 32'h0,        32'h0,        0,  0, 2'b00, 32'h0,        28'h0,       32'h0, 0,  9,  32'h0,        32'hDEADBEEF, 32'h0,        0, 32'h0);
    vecs[11] = mk(1, 0, 0, 32'h0,        32'h33333333, 9,  0, 2'b00, 32'h0,        28'h0,       32'h0, 9,  0,  32'hDEADBEEF, 32'h0,        32'h33333333, 0, 32'h0);
    vecs[12] = mk(1, 0, 1, 32'h44444444, 32'h55555555, 3,  1, 2'b01, 32'h00400010, 28'h0000100, 32'h0, 31, 3,  32'h00400010, 32'h0,        32'h00400010, 1, 32'h00000100);
    vecs[13] = mk(1, 0, 0, 32'h0,        32'h0,        0,  0, 2'b00, 32'h0,        28'h0,       32'h0, 31, 3,  32'h00400010, 32'h0,        32'h0,        0, 32'h00000100);
    vecs[14] = mk(1, 1, 0, 32'h0,        32'h5A5A0F0F, 17, 0, 2'b00, 32'h0,        28'h0,       32'h0, 17, 17, 32'h5A5A0F0F, 32'h5A5A0F0F, 32'h5A5A0F0F, 0, 32'h00000100);
    vecs[15] = mk(1, 0, 0, 32'h0,        32'h0,        0,  0, 2'b11, 32'hF0000000, 28'h0000ABC, 32'h77777777, 17, 31, 32'h5A5A0F0F, 32'h00400010, 32'h0, 0, 32'h00000100);

    for (int i = 0; i < 16; i++) apply($sformatf("v%0d", i), vecs[i]);

    // JR then J back-to-back: two consecutive pulses, each with its own target
    apply("jr", mk(1, 0, 0, 32'h0, 32'h0, 0, 0, 2'b10, 32'h0, 28'h0, 32'h00400020,
                   31, 0, 32'h00400010, 32'h0, 32'h0, 1, 32'h00400020));
    apply("j",  mk(1, 0, 0, 32'h0, 32'h0, 0, 0, 2'b01, 32'h10000004, 28'h0000040, 32'h0,
                   31, 0, 32'h00400010, 32'h0, 32'h0, 1, 32'h10000040));
    apply("jdone", mk(1, 0, 0, 32'h0, 32'h0, 0, 0, 2'b00, 32'h0, 28'h0, 32'h0,
                   31, 17, 32'h00400010, 32'h5A5A0F0F, 32'h0, 0, 32'h10000040));

    // Reset during a JR: redirect is dropped, target and registers clear
    apply("rstjr", mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 2'b10, 32'h0, 28'h0, 32'hCAFEBABE,
                   31, 17, 32'h00400010, 32'h5A5A0F0F, 32'h0, 0, 32'h0));
    apply("postrst", mk(1, 0, 0, 32'h0, 32'h0, 0, 0, 2'b00, 32'h0, 28'h0, 32'h0,
                   31, 17, 32'h0, 32'h0, 32'h0, 0, 32'h0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file for the 5-stage MIPS-32 pipeline. Consumes the MEM/WB pipeline register outputs and selects the write-back value: memory data, ALU result, or JAL link address. Commits that value into a 32x32 register file and serves the two ID-stage read ports with same-cycle write-through bypass. Also registers the J/JAL/JR redirect target resolved in WB and presents it to the fetch stage.

## Interface
Parameters:
- LINK_REG, 31, destination register index forced for JAL.

Ports:
- Clk  input  1  pipeline clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-low reset (sampled on rising Clk).
- RegWrite_WB  input  1  commit enable from MEM/WB.
- MemtoReg_WB  input  1  1 = write ReadData_WB, 0 = write ALUResult_WB.
- ReadData_WB  input  32  load data.
- ALUResult_WB  input  32  ALU result.
- WriteReg_WB  input  5  destination register.
- IsJal_WB  input  1  instruction is JAL; overrides data and destination.
- Jump_WB  input  2  00 none, 01 J/JAL absolute, 10 JR, 11 reserved (treated as none).
- PC_WB  input  32  PC+4 of the WB instruction.
- out1_WB  input  28  jump field already shifted left 2.
- ReadData1_WB  input  32  rs value for JR.
- ReadReg1_ID  input  5  read port 1 address.
- ReadReg2_ID  input  5  read port 2 address.
- ReadData1_ID  output  32  read port 1 data (combinational).
- ReadData2_ID  output  32  read port 2 data (combinational).
- WriteData_WB  output  32  selected write-back value (combinational, for forwarding).
- Redirect  output  1  registered one-cycle pulse: fetch must load Target.
- Target  output  32  registered redirect address.

## Operation
- Write value: IsJal_WB=1 -> PC_WB; else MemtoReg_WB=1 -> ReadData_WB; else ALUResult_WB.
- Write index: IsJal_WB=1 -> LINK_REG; else WriteReg_WB.
- Commit condition: (RegWrite_WB or IsJal_WB) and write index != 0. JAL commits even when RegWrite_WB=0.
- Register 0 is never written; it reads 0 at all times.
- Read ports: if the port address equals the committing index this cycle and the commit condition holds, return the write value (bypass); otherwise return the stored register. Address 0 always returns 0, including when bypass would apply.
- Both read ports may bypass simultaneously on the same index.
- Redirect target: Jump_WB=01 -> {PC_WB[31:28], out1_WB}; Jump_WB=10 -> ReadData1_WB. Jump_WB=00 or 11 -> no redirect.
- Redirect/Target are registered. Target holds its last value when Redirect=0.

## Timing
- Reset=0 at a rising edge: all 32 registers <- 0, Redirect <- 0, Target <- 0. Any commit or redirect presented in that cycle is dropped.
- Reset overrides everything; a reset asserted mid-sequence discards that cycle's WB instruction only. Previously committed state is cleared by the reset itself.
- Register commit takes effect at the rising edge ending the WB cycle. The stored value is visible from the next cycle; the same-cycle value is visible only through bypass.
- Redirect latency: 1 cycle. Jump_WB=01/10 in cycle N -> Redirect=1 and Target valid in cycle N+1. Redirect returns to 0 in cycle N+2 unless another jump is presented in cycle N+1.
- Back-to-back jumps produce back-to-back Redirect pulses, each carrying its own Target.
- WriteData_WB is combinational from the WB inputs, with zero latency.
- No stall input: every cycle's WB inputs are consumed.

## Test plan
- Reset: hold Reset=0 for 2 cycles after writing x5=0x1234 -> all reads return 0, Redirect=0, Target=0.
- ALU/load select: commit WriteReg=8 with ALUResult=0xA5A5A5A5 and MemtoReg=0; next cycle commit reg 9 with MemtoReg=1, ReadData=0xDEADBEEF -> reads of 8 and 9 return those values. Same-cycle read of 9 returns 0xDEADBEEF via bypass.
- $0 protection: RegWrite=1, WriteReg=0, ALUResult=0xFFFFFFFF -> ReadData1_ID on address 0 returns 0 in both the same cycle and the next cycle.
- JAL: IsJal=1, RegWrite=0, PC_WB=0x00400010, Jump=01, out1=0x0000100 -> x31=0x00400010. Next cycle Redirect=1, Target=0x00000100.
- JR then J back-to-back: Jump=10 with ReadData1=0x00400020, then Jump=01 with PC_WB=0x10000004 and out1=0x0000040 -> Redirect=1 for 2 consecutive cycles, Target=0x00400020 then 0x10000040, then Redirect=0.
- Reset during jump: Jump=10 presented with Reset=0 -> Redirect stays 0 and Target=0 on the following cycle.
